// File: rtl/present_dec_ctrl.sv
// Sequencer in front of the PRESENT_DECRYPT core. It assembles two 32-bit ciphertext words into a
// 64-bit block, starts the core, waits for done (bounded by TIMEOUT), optionally removes the CBC
// chaining and presents the plaintext on a valid/ready output. One block is in flight at a time.
module present_dec_ctrl #(
    parameter int unsigned CBC_EN  = 1,
    parameter int unsigned TIMEOUT = 96
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_load,
    input  logic [79:0] key_in,
    input  logic        iv_load,
    input  logic [63:0] iv_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        core_load,
    output logic        core_ce,
    output logic [63:0] core_idat,
    output logic [79:0] core_key,
    input  logic [63:0] core_odat,
    input  logic        core_done,
    output logic        busy,
    output logic        err_timeout,
    input  logic        clr_err
);

    // Counter wide enough to hold TIMEOUT-1 even for small TIMEOUT values.
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StW1,
        StLoad,
        StRun,
        StOut
    } state_t;

    state_t        state;
    logic [79:0]   key_reg;
    logic [63:0]   chain;
    logic [63:0]   ct_reg;
    logic [TW-1:0] tcnt;
    logic [63:0]   chain_mask;
    logic          in_acc;
    logic          tcnt_expired;

    // In ECB mode the chain never contributes to the plaintext.
    assign chain_mask   = (CBC_EN != 0) ? chain : 64'h0;
    assign in_acc       = in_valid & in_ready;
    assign tcnt_expired = (tcnt == TCNT_LAST);

    // The core sees the latched block and key directly; both only change while the core is idle.
    assign core_idat = ct_reg;
    assign core_key  = key_reg;
    assign busy      = (state != StIdle);

    // Control FSM: state, datapath registers and registered handshake/core outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            key_reg     <= 80'h0;
            chain       <= 64'h0;
            ct_reg      <= 64'h0;
            tcnt        <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= 64'h0;
            core_load   <= 1'b0;
            core_ce     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    // in_ready comes up one cycle after reset release and stays up through W1.
                    in_ready <= 1'b1;
                    if (key_load) begin
                        key_reg <= key_in;
                    end
                    if (iv_load && (CBC_EN != 0)) begin
                        chain <= iv_in;
                    end
                    if (in_acc) begin
                        ct_reg[63:32] <= in_data;
                        state         <= StW1;
                    end
                end

                StW1: begin
                    // Key/IV loads are ignored here: a partial block is held.
                    if (in_acc) begin
                        ct_reg[31:0] <= in_data;
                        in_ready     <= 1'b0;
                        core_load    <= 1'b1;
                        core_ce      <= 1'b1;
                        state        <= StLoad;
                    end
                end

                StLoad: begin
                    core_load <= 1'b0;
                    tcnt      <= '0;
                    state     <= StRun;
                end

                StRun: begin
                    tcnt <= tcnt + 1'b1;
                    if (core_done) begin
                        out_data  <= core_odat ^ chain_mask;
                        out_valid <= 1'b1;
                        core_ce   <= 1'b0;
                        state     <= StOut;
                        if (CBC_EN != 0) begin
                            chain <= ct_reg;
                        end
                    end else if (tcnt_expired) begin
                        // Abort: the block is dropped and the chain keeps its previous value.
                        err_timeout <= 1'b1;
                        core_ce     <= 1'b0;
                        in_ready    <= 1'b1;
                        state       <= StIdle;
                    end
                end

                StOut: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= StIdle;
                    end
                end

                default: begin
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    core_load <= 1'b0;
                    core_ce   <= 1'b0;
                    state     <= StIdle;
                end
            endcase

            // A clear request overrides a timeout raised in the same cycle.
            if (clr_err) begin
                err_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_present_dec_ctrl.sv
// Self-checking bench for present_dec_ctrl: a PRESENT-80 core model, a scoreboard fed at stimulus
// time and a monitor that pops on every accepted output beat.
module tb_present_dec_ctrl;

    localparam int CBC = 1;
    localparam int TMO = 96;

    logic        clk;
    logic        rst_n;
    logic        key_load;
    logic [79:0] key_in;
    logic        iv_load;
    logic [63:0] iv_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        core_load;
    logic        core_ce;
    logic [63:0] core_idat;
    logic [79:0] core_key;
    logic [63:0] core_odat;
    logic        core_done;
    logic        busy;
    logic        err_timeout;
    logic        clr_err;

    present_dec_ctrl #(
        .CBC_EN (CBC),
        .TIMEOUT(TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_load   (key_load),
        .key_in     (key_in),
        .iv_load    (iv_load),
        .iv_in      (iv_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .core_load  (core_load),
        .core_ce    (core_ce),
        .core_idat  (core_idat),
        .core_key   (core_key),
        .core_odat  (core_odat),
        .core_done  (core_done),
        .busy       (busy),
        .err_timeout(err_timeout),
        .clr_err    (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] sb_q[$];
    logic [79:0] m_key;
    logic [63:0] m_chain;
    logic [63:0] mon_exp;

    // Core model controls.
    bit          no_done = 1'b0;
    int          lat     = 64;
    bit          c_pend  = 1'b0;
    int          c_cnt   = 0;
    logic [63:0] c_res;

    // Output backpressure controls.
    bit hold_out = 1'b0;
    bit bp_rand  = 1'b0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic abort_run(input string name);
        failures++;
        $display("FAIL %s: wait bound expired", name);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "bench aborted");
    endtask

    // PRESENT-80 decryption straight from the cipher definition.
    function automatic logic [63:0] present_dec(input logic [63:0] ct, input logic [79:0] key);
        logic [3:0]  sb  [16];
        logic [3:0]  isb [16];
        logic [63:0] rk  [33];
        logic [79:0] k;
        logic [63:0] s;
        logic [63:0] t;
        sb = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
               4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
        for (int i = 0; i < 16; i++) isb[sb[i]] = 4'(i);
        k = key;
        rk[0] = 64'h0;
        for (int r = 1; r <= 32; r++) begin
            rk[r]     = k[79:16];
            k         = {k[18:0], k[79:19]};
            k[79:76]  = sb[k[79:76]];
            k[19:15]  = k[19:15] ^ 5'(r);
        end
        s = ct ^ rk[32];
        for (int r = 31; r >= 1; r--) begin
            for (int j = 0; j < 64; j++) t[j] = s[(j == 63) ? 63 : ((j * 16) % 63)];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = isb[t[4*n +: 4]];
            s = s ^ rk[r];
        end
        return s;
    endfunction

    // Core model: latches on load, answers lat enabled cycles later, silent while disabled.
    always @(negedge clk) begin
        if (!core_ce) begin
            c_pend    = 1'b0;
            core_done = 1'b0;
            core_odat = 64'h0;
        end else if (core_load) begin
            c_pend    = 1'b1;
            c_cnt     = 0;
            c_res     = present_dec(core_idat, core_key);
            core_done = 1'b0;
            core_odat = 64'h0;
        end else if (c_pend) begin
            c_cnt++;
            if (c_cnt == lat && !no_done) begin
                core_done = 1'b1;
                core_odat = c_res;
                c_pend    = 1'b0;
            end else begin
                core_done = 1'b0;
                core_odat = 64'h0;
            end
        end else begin
            core_done = 1'b0;
            core_odat = 64'h0;
        end
    end

    // Consumer: steady, held off, or randomly stalling.
    always @(posedge clk) begin
        #1;
        if (hold_out) out_ready = 1'b0;
        else if (bp_rand) out_ready = ($urandom_range(0, 2) != 0);
        else out_ready = 1'b1;
    end

    // Monitor: compares every output beat against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out: got %h expected no output", out_data);
            end else if (out_ready) begin
                mon_exp = sb_q.pop_front();
                chk("out_data", {16'h0, out_data}, {16'h0, mon_exp});
            end else begin
                chk("out_hold", {16'h0, out_data}, {16'h0, sb_q[0]});
            end
        end
    end

    task automatic send_word(input logic [31:0] w);
        int n;
        n        = 0;
        in_data  = w;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready) begin
            n++;
            if (n > 400) abort_run("in_ready_wait");
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic issue(input logic [63:0] ct, input int gap);
        send_word(ct[63:32]);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        send_word(ct[31:0]);
    endtask

    // Expected value from the reference model; advances the model chain.
    task automatic push_model(input logic [63:0] ct);
        sb_q.push_back(present_dec(ct, m_key) ^ ((CBC != 0) ? m_chain : 64'h0));
        if (CBC != 0) m_chain = ct;
    endtask

    // Expected value given literally by the known-answer vectors.
    task automatic push_lit(input logic [63:0] ct, input logic [63:0] exp);
        sb_q.push_back(exp);
        if (CBC != 0) m_chain = ct;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb_q.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 500) abort_run("out_wait");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_key(input logic [79:0] k);
        key_in   = k;
        key_load = 1'b1;
        @(posedge clk);
        #1;
        key_load = 1'b0;
        m_key    = k;
    endtask

    task automatic do_iv(input logic [63:0] v);
        iv_in   = v;
        iv_load = 1'b1;
        @(posedge clk);
        #1;
        iv_load = 1'b0;
        m_chain = v;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, {74'h0, in_ready, out_valid, core_load, core_ce, busy, err_timeout}, 80'h0);
        chk({name, "_data"}, {16'h0, out_data}, 80'h0);
        chk({name, "_idat"}, {16'h0, core_idat}, 80'h0);
        chk({name, "_key"}, core_key, 80'h0);
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs(name);
        sb_q.delete();
        m_key    = 80'h0;
        m_chain  = 64'h0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        abort_run("watchdog");
    end

    initial begin
        logic [63:0] ct;
        logic [79:0] k;
        int          n;
        rst_n    = 1'b0;
        key_load = 1'b0;
        key_in   = 80'h0;
        iv_load  = 1'b0;
        iv_in    = 64'h0;
        in_valid = 1'b0;
        in_data  = 32'h0;
        clr_err  = 1'b0;
        m_key    = 80'h0;
        m_chain  = 64'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset_state");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Known answer, key 0; a zero IV makes the chained output equal the raw plaintext.
        do_iv(64'h0);
        do_key(80'h0);
        send_word(32'h5579C138);
        send_word(32'h7B228445);
        push_lit(64'h5579C1387B228445, 64'h0);
        @(negedge clk);
        chk("load_pulse", {77'h0, core_load, core_ce, in_ready}, 80'h6);
        chk("load_idat", {16'h0, core_idat}, {16'h0, 64'h5579C1387B228445});
        chk("load_key", core_key, 80'h0);
        @(negedge clk);
        chk("run_ctrl", {77'h0, core_load, core_ce, busy}, 80'h3);
        wait_idle();

        // Known answer, all-ones key; busy spans first word to output accept.
        do_iv(64'h0);
        do_key({80{1'b1}});
        send_word(32'hE72C46C0);
        @(negedge clk);
        chk("busy_w1", {79'h0, busy}, 80'h1);
        @(posedge clk);
        #1;
        send_word(32'hF5945049);
        push_lit(64'hE72C46C0F5945049, 64'h0);
        repeat (30) @(negedge clk);
        chk("busy_run", {79'h0, busy}, 80'h1);
        wait_idle();
        @(negedge clk);
        chk("busy_idle", {79'h0, busy}, 80'h0);

        // CBC chaining over two identical blocks.
        do_key(80'h0);
        do_iv(64'h0123456789ABCDEF);
        issue(64'h5579C1387B228445, 0);
        push_lit(64'h5579C1387B228445, 64'h0123456789ABCDEF);
        wait_idle();
        issue(64'h5579C1387B228445, 2);
        push_lit(64'h5579C1387B228445, 64'h5579C1387B228445);
        wait_idle();

        // Backpressure; a key load during RUN must be ignored.
        do_key({$urandom, $urandom, 16'(($urandom))});
        hold_out = 1'b1;
        ct = {$urandom, $urandom};
        issue(ct, 1);
        push_model(ct);
        @(posedge clk);
        #1;
        key_in   = {$urandom, $urandom, 16'h5A5A};
        key_load = 1'b1;
        @(posedge clk);
        #1;
        key_load = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid) begin
            n++;
            if (n > 200) abort_run("bp_out_valid");
            @(negedge clk);
        end
        ct       = {$urandom, $urandom};
        in_data  = ct[63:32];
        in_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("bp_hold", {77'h0, out_valid, in_ready, core_ce}, 80'h4);
        end
        hold_out = 1'b0;
        issue(ct, 0);
        push_model(ct);
        wait_idle();

        // Timeout: exact abort cycle, error flag, clear, clear-over-set, chain kept.
        no_done = 1'b1;
        issue({$urandom, $urandom}, 0);
        repeat (TMO) @(posedge clk);
        #1;
        chk("tmo_before", {78'h0, err_timeout, busy}, 80'h1);
        @(posedge clk);
        #1;
        chk("tmo_abort", {77'h0, err_timeout, busy, core_ce}, 80'h4);
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        chk("tmo_clear", {79'h0, err_timeout}, 80'h0);
        issue({$urandom, $urandom}, 1);
        repeat (TMO) @(posedge clk);
        #1;
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        chk("tmo_clr_wins", {78'h0, err_timeout, busy}, 80'h0);
        no_done = 1'b0;
        ct = {$urandom, $urandom};
        issue(ct, 0);
        push_model(ct);
        wait_idle();

        // Reset mid-RUN and with one word held, then a clean block.
        issue({$urandom, $urandom}, 0);
        repeat (20) @(posedge clk);
        #1;
        do_reset("rst_run");
        send_word($urandom);
        do_reset("rst_w1");
        issue(64'h5579C1387B228445, 0);
        push_lit(64'h5579C1387B228445, 64'h0);
        wait_idle();

        // Randomised blocks: key/IV loads, key load with first word, ignored loads in W1.
        bp_rand = 1'b1;
        for (int b = 0; b < 40; b++) begin
            if ($urandom_range(0, 1) == 1) do_key({$urandom, $urandom, 16'(($urandom))});
            if ($urandom_range(0, 4) == 0) do_iv({$urandom, $urandom});
            lat = $urandom_range(1, 90);
            ct  = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) begin
                k        = {$urandom, $urandom, 16'(($urandom))};
                key_in   = k;
                key_load = 1'b1;
                send_word(ct[63:32]);
                key_load = 1'b0;
                m_key    = k;
            end else begin
                send_word(ct[63:32]);
            end
            if ($urandom_range(0, 2) == 0) begin
                key_in   = {$urandom, $urandom, 16'hC3C3};
                key_load = 1'b1;
                iv_in    = {$urandom, $urandom};
                iv_load  = 1'b1;
                @(posedge clk);
                #1;
                key_load = 1'b0;
                iv_load  = 1'b0;
            end
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            send_word(ct[31:0]);
            push_model(ct);
            wait_idle();
        end
        bp_rand = 1'b0;
        repeat (4) @(posedge clk);
        chk("sb_empty", 80'(sb_q.size()), 80'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
